// File: rtl/alu_sequencer_pkg.sv
// Shared widths, state encoding and instruction layout for the ALU sequencer.
package alu_sequencer_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned BUS_WIDTH    = 4;
  localparam int unsigned OPCODE_WIDTH = 6;
  localparam int unsigned PC_WIDTH     = 8;
  localparam int unsigned INSTR_WIDTH  = OPCODE_WIDTH + 2 * BUS_WIDTH;
  localparam int unsigned REG_DEPTH    = 2 ** BUS_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OPC_NOP    = '0;
  localparam logic [OPCODE_WIDTH-1:0] OPC_FINISH = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_HALT,
    S_FAULT
  } seq_state_t;

  // Instruction word layout {opcode, addr1, addr2}
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [BUS_WIDTH-1:0]    addr1;
    logic [BUS_WIDTH-1:0]    addr2;
  } instr_t;

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file: two combinational read ports, a debug read port, one synchronous write port.
module alu_sequencer_regfile
  import alu_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we_i,
  input  logic [BUS_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BUS_WIDTH-1:0]  raddr1_i,
  input  logic [BUS_WIDTH-1:0]  raddr2_i,
  input  logic [BUS_WIDTH-1:0]  dbg_addr_i,
  output logic [DATA_WIDTH-1:0] rdata1_c_o,
  output logic [DATA_WIDTH-1:0] rdata2_c_o,
  output logic [DATA_WIDTH-1:0] dbg_data_c_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_DEPTH];

  // Storage with asynchronous clear and single write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_c_o   = regs_q[raddr1_i];
  assign rdata2_c_o   = regs_q[raddr2_i];
  assign dbg_data_c_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving the ALU request interface.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    imem_req,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic                    imem_valid,
  input  logic [INSTR_WIDTH-1:0]  imem_rdata,
  output logic                    alu_en,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [DATA_WIDTH-1:0]   alu_value1,
  output logic [DATA_WIDTH-1:0]   alu_value2,
  output logic [BUS_WIDTH-1:0]    alu_addr1,
  output logic [BUS_WIDTH-1:0]    alu_addr2,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_calc_done,
  input  logic                    alu_err,
  input  logic                    alu_finish,
  input  logic [BUS_WIDTH-1:0]    dbg_addr,
  output logic [DATA_WIDTH-1:0]   dbg_data,
  output logic                    busy,
  output logic                    halted,
  output logic                    fault,
  output logic [PC_WIDTH-1:0]     pc
);

  seq_state_t              state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  instr_t                  ir_q, ir_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [BUS_WIDTH-1:0]    addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_WIDTH-1:0]   val1_q, val1_d, val2_q, val2_d;
  logic                    imem_req_q, imem_req_d;
  logic                    alu_en_q, alu_en_d;
  logic                    busy_q, busy_d;
  logic                    halted_q, halted_d;
  logic                    fault_q, fault_d;
  logic                    we_c;
  logic [DATA_WIDTH-1:0]   rdata1_c, rdata2_c;

  // Finish is detected from the decoded opcode; the ALU's flag is not needed
  logic unused_alu_finish;
  assign unused_alu_finish = alu_finish;

  alu_sequencer_regfile u_regfile (
    .clk          (clk),
    .rstn         (rstn),
    .we_i         (we_c),
    .waddr_i      (addr1_q),
    .wdata_i      (alu_result),
    .raddr1_i     (ir_q.addr1),
    .raddr2_i     (ir_q.addr2),
    .dbg_addr_i   (dbg_addr),
    .rdata1_c_o   (rdata1_c),
    .rdata2_c_o   (rdata2_c),
    .dbg_data_c_o (dbg_data)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      opcode_q   <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      val1_q     <= '0;
      val2_q     <= '0;
      imem_req_q <= 1'b0;
      alu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      opcode_q   <= opcode_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      imem_req_q <= imem_req_d;
      alu_en_q   <= alu_en_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state, datapath updates and registered-output decode of the next state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opcode_d = opcode_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    val1_d   = val1_q;
    val2_d   = val2_q;
    we_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = instr_t'(imem_rdata);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q.opcode == OPC_FINISH) begin
          state_d = S_HALT;
        end else if (ir_q.opcode == OPC_NOP) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_FETCH;
        end else begin
          opcode_d = ir_q.opcode;
          addr1_d  = ir_q.addr1;
          addr2_d  = ir_q.addr2;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        val1_d  = rdata1_c;
        val2_d  = rdata2_c;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (alu_err)            state_d = S_FAULT;
        else if (alu_calc_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        we_c    = 1'b1;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_FETCH;
      end
      S_HALT, S_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    imem_req_d = (state_d == S_FETCH);
    alu_en_d   = (state_d == S_CALC);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_FAULT));
    halted_d   = (state_d == S_HALT);
    fault_d    = (state_d == S_FAULT);
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign alu_en     = alu_en_q;
  assign alu_opcode = opcode_q;
  assign alu_addr1  = addr1_q;
  assign alu_addr2  = addr2_q;
  assign alu_value1 = val1_q;
  assign alu_value2 = val2_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign pc         = pc_q;

endmodule
